// File: rtl/random_delay_generator.sv
// Reaction-timer front end: waits MIN_MS plus a pseudo-random number of milliseconds
// after an arm tick, then lights the stimulus LED and flags presses that come too early.
module random_delay_generator #(
  parameter int unsigned             MS_TICKS  = 100000,
  parameter int unsigned             MIN_MS    = 2000,
  parameter int unsigned             LFSR_N    = 13,
  parameter logic [LFSR_N-1:0]       LFSR_TAPS = 13'h1C80,
  parameter logic [LFSR_N-1:0]       SEED      = 13'h1ACE,
  parameter int unsigned             DELAY_W   = 16
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               arm_i,
  input  logic               abort_i,
  input  logic               stop_i,
  output logic               stimulus_o,
  output logic               go_tick_o,
  output logic               early_o,
  output logic               busy_o,
  output logic [DELAY_W-1:0] delay_ms_o
);

  localparam int unsigned        PRE_W     = $clog2(MS_TICKS);
  localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(MS_TICKS - 1);
  localparam logic [LFSR_N-1:0]  LFSR_INIT = (SEED == '0) ? LFSR_N'(1) : SEED;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STIM, S_EARLY} state_t;

  state_t             state;
  logic [LFSR_N-1:0]  lfsr;
  logic [PRE_W-1:0]   prescaler;
  logic [DELAY_W-1:0] ms_count;
  logic               expiry;

  // Last cycle of the final millisecond: the LED lights on the following edge.
  assign expiry = (prescaler == PRE_LAST) && (ms_count == delay_ms_o - DELAY_W'(1));

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state      <= S_IDLE;
      lfsr       <= LFSR_INIT;
      prescaler  <= '0;
      ms_count   <= '0;
      delay_ms_o <= '0;
      stimulus_o <= 1'b0;
      go_tick_o  <= 1'b0;
      early_o    <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      lfsr      <= {lfsr[LFSR_N-2:0], ^(lfsr & LFSR_TAPS)};
      go_tick_o <= 1'b0;
      if (abort_i) begin
        state      <= S_IDLE;
        stimulus_o <= 1'b0;
        early_o    <= 1'b0;
        busy_o     <= 1'b0;
        prescaler  <= '0;
        ms_count   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (arm_i) begin
              delay_ms_o <= DELAY_W'(MIN_MS) + DELAY_W'(lfsr);
              prescaler  <= '0;
              ms_count   <= '0;
              busy_o     <= 1'b1;
              state      <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (stop_i) begin
              state   <= S_EARLY;
              early_o <= 1'b1;
              busy_o  <= 1'b0;
            end else if (expiry) begin
              state      <= S_STIM;
              stimulus_o <= 1'b1;
              go_tick_o  <= 1'b1;
            end else if (prescaler == PRE_LAST) begin
              prescaler <= '0;
              ms_count  <= ms_count + DELAY_W'(1);
            end else begin
              prescaler <= prescaler + PRE_W'(1);
            end
          end
          S_STIM: begin
            if (stop_i) begin
              state      <= S_IDLE;
              stimulus_o <= 1'b0;
              busy_o     <= 1'b0;
            end
          end
          S_EARLY: begin
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_random_delay_generator.sv
// Bench for random_delay_generator: deadline-based reference model checked every cycle,
// plus directed checks of the documented LFSR values and timing corners.
module tb_random_delay_generator;

  logic       clk_i = 1'b0;
  logic       reset_ni = 1'b0;
  logic       arm_i = 1'b0, abort_i = 1'b0, stop_i = 1'b0;
  logic       stimulus_o, go_tick_o, early_o, busy_o;
  logic [7:0] delay_ms_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  random_delay_generator #(
    .MS_TICKS (4),
    .MIN_MS   (3),
    .LFSR_N   (4),
    .LFSR_TAPS(4'hC),
    .SEED     (4'h9),
    .DELAY_W  (8)
  ) dut (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .arm_i     (arm_i),
    .abort_i   (abort_i),
    .stop_i    (stop_i),
    .stimulus_o(stimulus_o),
    .go_tick_o (go_tick_o),
    .early_o   (early_o),
    .busy_o    (busy_o),
    .delay_ms_o(delay_ms_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    else n_pass++;
  endtask

  // Reference model: tracks the absolute edge at which the LED must light.
  typedef enum {M_IDLE, M_WAIT, M_STIM, M_EARLY} mode_t;
  mode_t       m_mode = M_IDLE;
  int unsigned cyc = 0, m_deadline = 0;
  logic [3:0]  m_lfsr = 4'h9;
  logic [7:0]  m_delay = '0;
  logic        m_stim = 0, m_go = 0, m_early = 0, m_busy = 0, m_valid = 0;

  always @(posedge clk_i) begin
    cyc++;
    if (!reset_ni) begin
      m_mode = M_IDLE; m_lfsr = 4'h9; m_delay = '0;
      m_stim = 0; m_go = 0; m_early = 0; m_busy = 0; m_valid = 1;
    end else begin
      m_go = 0;
      if (abort_i) begin
        m_mode = M_IDLE; m_stim = 0; m_early = 0; m_busy = 0;
      end else begin
        case (m_mode)
          M_IDLE: if (arm_i) begin
            m_delay    = 8'(3 + m_lfsr);
            m_deadline = cyc + 4 * m_delay;
            m_mode     = M_WAIT;
            m_busy     = 1;
          end
          M_WAIT: if (stop_i) begin
            m_mode = M_EARLY; m_early = 1; m_busy = 0;
          end else if (cyc == m_deadline) begin
            m_mode = M_STIM; m_stim = 1; m_go = 1;
          end
          M_STIM: if (stop_i) begin
            m_mode = M_IDLE; m_stim = 0; m_busy = 0;
          end
          default: ;
        endcase
      end
      m_lfsr = {m_lfsr[2:0], m_lfsr[3] ^ m_lfsr[2]};
    end
  end

  always @(negedge clk_i)
    if (m_valid)
      check("outs", {20'd0, stimulus_o, go_tick_o, early_o, busy_o, delay_ms_o},
                    {20'd0, m_stim, m_go, m_early, m_busy, m_delay});

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic pulse_arm();   arm_i = 1;   step(1); arm_i = 0;   endtask
  task automatic pulse_stop();  stop_i = 1;  step(1); stop_i = 0;  endtask
  task automatic pulse_abort(); abort_i = 1; step(1); abort_i = 0; endtask

  // One reset edge, then arm on the first edge after release (LFSR = seed).
  task automatic reset_and_arm();
    reset_ni = 0; step(1); reset_ni = 1;
    pulse_arm();
  endtask

  initial begin
    logic seen;
    step(2);
    check("reset_outs", {stimulus_o, go_tick_o, early_o, busy_o, delay_ms_o}, 12'h000);

    // Nominal: delay 12 ms -> LED after 48 edges
    reset_ni = 1; pulse_arm();
    check("delay_first", delay_ms_o, 12);
    check("busy_arm", busy_o, 1);
    step(47);
    check("stim_before", stimulus_o, 0);
    step(1);
    check("stim_rise", {stimulus_o, go_tick_o}, 2'b11);
    step(1);
    check("go_one_cycle", {stimulus_o, go_tick_o, busy_o}, 3'b101);
    step(5);
    pulse_stop();
    check("stop_in_stim", {stimulus_o, busy_o}, 2'b00);

    // Second LFSR value: arm one cycle later
    reset_ni = 0; step(1); reset_ni = 1; step(1);
    pulse_arm();
    check("delay_second", delay_ms_o, 6);
    pulse_abort();

    // Early press, further arm ignored, abort clears
    reset_and_arm();
    step(10); pulse_stop();
    check("early_set", {early_o, busy_o, stimulus_o}, 3'b100);
    pulse_arm();
    check("early_arm_ign", {early_o, busy_o, delay_ms_o}, {2'b10, 8'd12});
    seen = 0;
    for (int i = 0; i < 60; i++) begin step(1); seen |= go_tick_o | stimulus_o; end
    check("early_no_go", seen, 0);
    pulse_abort();
    check("early_abort", {early_o, busy_o}, 2'b00);

    // Stop coincident with expiry cycle
    reset_and_arm();
    step(47); pulse_stop();
    check("stop_at_expiry", {early_o, stimulus_o, go_tick_o}, 3'b100);
    pulse_abort();

    // Abort mid-WAIT
    reset_and_arm();
    step(19); pulse_abort();
    seen = 0;
    for (int i = 0; i < 100; i++) begin step(1); seen |= stimulus_o | busy_o; end
    check("abort_wait", seen, 0);

    // Arm during WAIT does not restart the delay
    reset_and_arm();
    step(10); pulse_arm();
    step(36);
    check("rearm_before", stimulus_o, 0);
    step(1);
    check("rearm_rise", {stimulus_o, go_tick_o}, 2'b11);

    // Synchronous reset while in STIM
    reset_ni = 0; step(1);
    check("reset_in_stim", {stimulus_o, go_tick_o, early_o, busy_o, delay_ms_o}, 12'h000);
    reset_ni = 1; pulse_arm();
    check("lfsr_reseeded", delay_ms_o, 12);
    // Reset pulse with no clock edge inside it
    reset_ni = 0; #1;
    check("reset_no_edge", {stimulus_o, go_tick_o, early_o, busy_o, delay_ms_o}, {4'b0001, 8'd12});
    #1 reset_ni = 1;
    step(1);
    pulse_abort();

    // Randomized sessions
    for (int it = 0; it < 40; it++) begin
      int unsigned kind;
      step($urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) begin reset_ni = 0; step(1); reset_ni = 1; end
      pulse_arm();
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin step($urandom_range(0, 75)); pulse_stop(); end
        1: begin step($urandom_range(0, 75)); pulse_abort(); end
        2: begin step(75 + $urandom_range(0, 5)); pulse_stop(); end
        default: begin
          step($urandom_range(1, 20)); pulse_arm();
          step($urandom_range(0, 60)); pulse_stop();
        end
      endcase
      step($urandom_range(0, 3));
      pulse_abort();
    end

    step(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
